setup_hold_monitor: RTL and testbench
=====================================

SETUP_HOLD_MONITOR -- requirements
Module: setup_hold_monitor

Interface
REQ-001 Parameter CHANNELS, default 4, sets the number of monitored data bits; legal range 1..32.
REQ-002 Parameter SETUP_LIMIT, default 10, sets the setup window in clk cycles; legal range 1..255.
REQ-003 Parameter HOLD_LIMIT, default 2, sets the hold window in clk cycles; legal range 1..255.
REQ-004 Parameter CNT_W, default 8, sets the violation counter width.
REQ-005 clk  input  1  the single sampling clock; all state advances on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 data  input  CHANNELS  monitored signals, synchronous to clk.
REQ-008 strobe  input  1  reference event; its rising edge is the checked event.
REQ-009 cond  input  1  event condition; a strobe edge is checked only when cond=1 in the edge-detect cycle.
REQ-010 clear  input  1  synchronous clear of sticky flags and counter.
REQ-011 viol_setup  output  CHANNELS  sticky per-channel setup-violation flags.
REQ-012 viol_hold  output  CHANNELS  sticky per-channel hold-violation flags.
REQ-013 viol_pulse  output  1  one-cycle pulse for each cycle in which any new violation is detected.
REQ-014 viol_count  output  CNT_W  saturating count of violation-detect cycles.

Function
REQ-015 The block SHALL register data into data_q each cycle; change[i] = data[i] XOR data_q[i].
REQ-016 The block SHALL detect a strobe edge as strobe=1 while strobe_q=0; the qualified edge is edge AND cond.
REQ-017 The per-channel age counter SHALL load 0 on change[i]; otherwise it increments and saturates at SETUP_LIMIT.
REQ-018 On a qualified edge, channel i SHALL flag a setup violation if change[i]=1 or age[i] < SETUP_LIMIT.
REQ-019 The hold FSM SHALL have two states: IDLE and HOLD. A qualified edge enters HOLD with hold_cnt = HOLD_LIMIT.
REQ-020 In HOLD, hold_cnt SHALL decrement each cycle, and a change[i] flags a hold violation on channel i. The FSM returns to IDLE after the cycle in which hold_cnt = 1.
REQ-021 A qualified edge while in HOLD SHALL reload hold_cnt = HOLD_LIMIT, and that same cycle SHALL also be evaluated for setup.
REQ-022 A change in the qualified-edge cycle itself SHALL count as setup only, never as hold.
REQ-023 All outputs SHALL be registered; flags and the pulse appear 1 cycle after the detect cycle.
REQ-024 viol_count SHALL increment by 1 per detect cycle, regardless of how many channels or kinds violate, and saturate at 2^CNT_W-1.
REQ-025 A clear in the same cycle as a detect SHALL take priority: flags and count go to 0, while viol_pulse still asserts.
REQ-026 An unqualified edge (cond=0) SHALL have no effect on flags, count, or the FSM.

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be IDLE, hold_cnt SHALL be 0, strobe_q SHALL be 0, data_q SHALL be 0, and all age counters SHALL be SETUP_LIMIT.
REQ-028 Reset asserted mid-HOLD SHALL abort the window immediately; no hold flag may result from pre-reset changes.
REQ-029 The first cycle after reset deassertion SHALL suppress change detection so that data_q can load.

Configuration
REQ-030 Macro SHM_HOLD_CHECK_EN: when defined, the hold FSM and viol_hold SHALL be implemented per REQ-019..022.
REQ-031 When SHM_HOLD_CHECK_EN is undefined, the FSM SHALL be omitted, viol_hold SHALL be tied to 0, and only setup violations drive viol_pulse and viol_count.

Verification (CHANNELS=4, SETUP_LIMIT=10, HOLD_LIMIT=2, CNT_W=8, macro defined)
REQ-032 data[0] toggles, then 12 cycles later strobe rises with cond=1 -> no flags set, viol_count=0.
REQ-033 data[2] toggles, then 3 cycles later a qualified edge -> viol_setup=4'b0100 and viol_pulse high for 1 cycle, both 1 cycle after the edge; viol_count=1.
REQ-034 Same as REQ-033 but with cond=0 -> all outputs stay 0.
REQ-035 Qualified edge, then data[1] toggles 2 cycles later -> viol_hold=4'b0010; a toggle at 3 cycles after the edge -> no hold flag.
REQ-036 Force 300 setup violations -> viol_count holds at 255; clear asserted together with a new violation -> flags=0, count=0, viol_pulse=1.
REQ-037 rst_n pulled low 1 cycle into HOLD, then a data toggle after release -> no viol_hold and FSM in IDLE.

Source files
------------

// File: rtl/setup_hold_monitor.sv
// Setup/hold timing monitor: per-channel data age vs. a qualified strobe edge, with sticky flags.
// Optional hold-window checking is built when SHM_HOLD_CHECK_EN is defined.

module shm_age_lane #(
  parameter int SETUP_LIMIT = 10,
  parameter int AGE_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chg,
  output logic [AGE_W-1:0] age
);
  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (chg)                               age_d = '0;
    else if (age_q != AGE_W'(SETUP_LIMIT)) age_d = age_q + AGE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age_q <= AGE_W'(SETUP_LIMIT);
    else        age_q <= age_d;

  assign age = age_q;
endmodule

module setup_hold_monitor #(
  parameter int CHANNELS    = 4,
  parameter int SETUP_LIMIT = 10,
  parameter int HOLD_LIMIT  = 2,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] data,
  input  logic                strobe,
  input  logic                cond,
  input  logic                clear,
  output logic [CHANNELS-1:0] viol_setup,
  output logic [CHANNELS-1:0] viol_hold,
  output logic                viol_pulse,
  output logic [CNT_W-1:0]    viol_count
);
  localparam int AGE_W = $clog2(SETUP_LIMIT + 1);

  if (CHANNELS < 1 || CHANNELS > 32 || SETUP_LIMIT < 1 || SETUP_LIMIT > 255 ||
      HOLD_LIMIT < 1 || HOLD_LIMIT > 255 || CNT_W < 1) begin : g_bad_param
    $error("setup_hold_monitor: parameter out of range");
  end

  logic                init_q;
  logic                strobe_q;
  logic [CHANNELS-1:0] data_q;
  logic [CHANNELS-1:0] change, setup_hit, hold_hit;
  logic                str_edge, qedge, detect;

  // init_q masks the first post-reset cycle, where data_q still holds its reset value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      init_q   <= 1'b0;
      strobe_q <= 1'b0;
      data_q   <= '0;
    end else begin
      init_q   <= 1'b1;
      strobe_q <= strobe;
      data_q   <= data;
    end

  assign change   = init_q ? (data ^ data_q) : '0;
  assign str_edge = strobe & ~strobe_q;
  assign qedge    = str_edge & cond;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [AGE_W-1:0] age;
    shm_age_lane #(.SETUP_LIMIT(SETUP_LIMIT), .AGE_W(AGE_W)) u_age (
      .clk(clk), .rst_n(rst_n), .chg(change[i]), .age(age)
    );
    assign setup_hit[i] = qedge & (change[i] | (age < AGE_W'(SETUP_LIMIT)));
  end

`ifdef SHM_HOLD_CHECK_EN
  localparam int HC_W = $clog2(HOLD_LIMIT + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CHANNELS-1:0] viol_hold_q, viol_hold_d;

  // A change in the edge cycle itself is a setup matter, so hold is masked on qedge
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    hold_hit   = '0;
    if (qedge) begin
      state_d    = S_HOLD;
      hold_cnt_d = HC_W'(HOLD_LIMIT);
    end else if (state_q == S_HOLD) begin
      hold_hit   = change;
      hold_cnt_d = hold_cnt_q - HC_W'(1);
      if (hold_cnt_q == HC_W'(1)) state_d = S_IDLE;
    end
  end

  always_comb viol_hold_d = clear ? '0 : (viol_hold_q | hold_hit);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      viol_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      viol_hold_q <= viol_hold_d;
    end

  assign viol_hold = viol_hold_q;
`else
  assign hold_hit  = '0;
  assign viol_hold = '0;
`endif

  logic [CHANNELS-1:0] viol_setup_q, viol_setup_d;
  logic                viol_pulse_q, viol_pulse_d;
  logic [CNT_W-1:0]    viol_count_q, viol_count_d;

  assign detect = (|setup_hit) | (|hold_hit);

  // clear wins over a simultaneous detect, but the pulse still reports it
  always_comb begin
    viol_pulse_d = detect;
    viol_setup_d = viol_setup_q | setup_hit;
    viol_count_d = viol_count_q;
    if (detect && viol_count_q != {CNT_W{1'b1}}) viol_count_d = viol_count_q + CNT_W'(1);
    if (clear) begin
      viol_setup_d = '0;
      viol_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      viol_setup_q <= '0;
      viol_pulse_q <= 1'b0;
      viol_count_q <= '0;
    end else begin
      viol_setup_q <= viol_setup_d;
      viol_pulse_q <= viol_pulse_d;
      viol_count_q <= viol_count_d;
    end

  assign viol_setup = viol_setup_q;
  assign viol_pulse = viol_pulse_q;
  assign viol_count = viol_count_q;
endmodule

// File: tb/tb_setup_hold_monitor.sv
// Directed bench for setup_hold_monitor (CHANNELS=4, SETUP_LIMIT=10, HOLD_LIMIT=2, CNT_W=8).
// Hold expectations follow whether SHM_HOLD_CHECK_EN is defined for this build.

module tb_setup_hold_monitor;
`ifdef SHM_HOLD_CHECK_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data;
  logic       strobe, cond, clear;
  logic [3:0] viol_setup, viol_hold;
  logic       viol_pulse;
  logic [7:0] viol_count;
  logic [16:0] got, exp_v;
  int checks = 0;
  int failures = 0;

  setup_hold_monitor #(.CHANNELS(4), .SETUP_LIMIT(10), .HOLD_LIMIT(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .strobe(strobe), .cond(cond), .clear(clear),
    .viol_setup(viol_setup), .viol_hold(viol_hold), .viol_pulse(viol_pulse),
    .viol_count(viol_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // outputs packed as {viol_setup, viol_hold, viol_pulse, viol_count}
  task automatic test_reset;
    rst_n = 1'b0; data = '0; strobe = 0; cond = 0; clear = 0;
    step(2);
    got = {viol_setup, viol_hold, viol_pulse, viol_count}; exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", got, exp_v);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_setup_ok;
    data[0] = ~data[0];
    step(12);
    strobe = 1; cond = 1;
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count}; exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL setup_ok_edge got=%h exp=%h", got, exp_v);
    end
    strobe = 0; cond = 0;
    step(3);
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL setup_ok_after got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_cond_low;
    data[2] = ~data[2];
    step(3);
    strobe = 1; cond = 0;
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count}; exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL cond_low_edge got=%h exp=%h", got, exp_v);
    end
    strobe = 0;
    step(2);
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL cond_low_after got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_setup_viol;
    step(12);
    data[2] = ~data[2];
    step(3);
    strobe = 1; cond = 1;
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    exp_v = {4'b0100, 4'b0000, 1'b1, 8'd1};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL setup_viol_edge got=%h exp=%h", got, exp_v);
    end
    strobe = 0; cond = 0;
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    exp_v = {4'b0100, 4'b0000, 1'b0, 8'd1};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL setup_viol_pulse_drop got=%h exp=%h", got, exp_v);
    end
    clear = 1;
    step();
    clear = 0;
    got = {viol_setup, viol_hold, viol_pulse, viol_count}; exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL setup_viol_clear got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_hold;
    step(12);
    strobe = 1; cond = 1;
    step();
    strobe = 0; cond = 0;
    step();
    data[1] = ~data[1];
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    exp_v = {4'b0000, HOLD_EN ? 4'b0010 : 4'b0000, HOLD_EN, HOLD_EN ? 8'd1 : 8'd0};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL hold_at_2 got=%h exp=%h", got, exp_v);
    end
    clear = 1;
    step();
    clear = 0;
    step(12);
    strobe = 1; cond = 1;
    step();
    strobe = 0; cond = 0;
    step(2);
    data[1] = ~data[1];
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count}; exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL hold_at_3 got=%h exp=%h", got, exp_v);
    end
    step(12);
    data[3] = ~data[3]; strobe = 1; cond = 1;
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    exp_v = {4'b1000, 4'b0000, 1'b1, 8'd1};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL edge_cycle_change got=%h exp=%h", got, exp_v);
    end
    strobe = 0; cond = 0;
    step(3);
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    exp_v = {4'b1000, 4'b0000, 1'b0, 8'd1};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL edge_cycle_change_after got=%h exp=%h", got, exp_v);
    end
    clear = 1;
    step();
    clear = 0;
  endtask

  task automatic test_saturate;
    step(12);
    for (int i = 0; i < 300; i++) begin
      data[0] = ~data[0]; strobe = 1; cond = 1;
      step();
      strobe = 0; cond = 0;
      step();
    end
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    exp_v = {4'b0001, 4'b0000, 1'b0, 8'd255};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL count_saturate got=%h exp=%h", got, exp_v);
    end
    clear = 1; data[0] = ~data[0]; strobe = 1; cond = 1;
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    exp_v = {4'b0000, 4'b0000, 1'b1, 8'd0};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL clear_with_detect got=%h exp=%h", got, exp_v);
    end
    clear = 0; strobe = 0; cond = 0;
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count}; exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL after_clear got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_reset_mid_hold;
    step(12);
    strobe = 1; cond = 1;
    step();
    strobe = 0; cond = 0;
    rst_n = 1'b0; data[1] = ~data[1];
    #1;
    got = {viol_setup, viol_hold, viol_pulse, viol_count}; exp_v = '0;
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", got, exp_v);
    end
    step(2);
    rst_n = 1'b1;
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", got, exp_v);
    end
    data[1] = ~data[1];
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL post_reset_toggle got=%h exp=%h", got, exp_v);
    end
    // one more toggle on the next cycle: would land in a stale hold window
    data[2] = ~data[2];
    step();
    got = {viol_setup, viol_hold, viol_pulse, viol_count};
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL post_reset_toggle2 got=%h exp=%h", got, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_setup_ok();
    test_cond_low();
    test_setup_viol();
    test_hold();
    test_saturate();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
